// File: rtl/axi_st_csr_ctrl_multi.sv
// CSR block for multi-link AXI-ST H2H: per-link control/status/snapshot windows,
// a global window, and a timed active-low datapath reset generator.
`timescale 1ns/1ps
module axi_st_csr_ctrl_multi #(
    parameter int          LINKS    = 2,
    parameter int          SNAP_W   = 64,
    parameter int          ADDR_W   = 16,
    parameter int          RST_HOLD = 16,
    parameter logic [31:0] VERSION  = 32'h0002_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        wr_rd_addr,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [31:0]              wr_data,
    output logic [31:0]              rd_datain,
    output logic                     rd_dvalid,
    input  logic [2*LINKS-1:0]       chkr_pass,
    input  logic [LINKS-1:0]         align_error,
    input  logic [3:0]               online,
    input  logic [LINKS*SNAP_W-1:0]  data_out_first,
    input  logic [LINKS*SNAP_W-1:0]  data_out_last,
    input  logic [LINKS*SNAP_W-1:0]  data_in_first,
    input  logic [LINKS*SNAP_W-1:0]  data_in_last,
    input  logic [LINKS-1:0]         data_out_first_valid,
    input  logic [LINKS-1:0]         data_out_last_valid,
    input  logic [LINKS-1:0]         data_in_first_valid,
    input  logic [LINKS-1:0]         data_in_last_valid,
    output logic [LINKS-1:0]         csr_patgen_en,
    output logic [2*LINKS-1:0]       csr_patgen_sel,
    output logic [9*LINKS-1:0]       csr_patgen_cnt,
    output logic [LINKS-1:0]         csr_cntuspatt_en,
    output logic [31:0]              o_delay_x_value,
    output logic [31:0]              o_delay_y_value,
    output logic [31:0]              o_delay_z_value,
    output logic                     axist_rstn_out
);

    // state | meaning
    // HOLD  | axist_rstn_out low, down-counter running
    // RUN   | axist_rstn_out high
    typedef enum logic {HOLD = 1'b0, RUN = 1'b1} rst_state_t;

    localparam int NW    = SNAP_W / 32;
    localparam int WIN_W = ADDR_W - 8;
    localparam int CNT_W = $clog2(RST_HOLD + 1);
    localparam logic [WIN_W-1:0] WIN_GLB = WIN_W'(15);
    localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(RST_HOLD);

    logic [WIN_W-1:0] win;
    logic [5:0]       word_addr;
    logic [2:0]       grp;
    logic [2:0]       wsel;
    logic             unused_addr_lsb;

    assign win             = wr_rd_addr[ADDR_W-1:8];
    assign word_addr       = wr_rd_addr[7:2];
    assign grp             = word_addr[5:3];
    assign wsel            = word_addr[2:0];
    assign unused_addr_lsb = ^wr_rd_addr[1:0];

    logic [12:0]       ctrl_q   [LINKS];
    logic [15:0]       errcnt_q [LINKS];
    logic [SNAP_W-1:0] snap_of_q[LINKS];
    logic [SNAP_W-1:0] snap_ol_q[LINKS];
    logic [SNAP_W-1:0] snap_if_q[LINKS];
    logic [SNAP_W-1:0] snap_il_q[LINKS];
    logic [LINKS-1:0]  sticky_q, align_q, arm_of_q, arm_if_q;
    logic [31:0]       delay_x_q, delay_y_q, delay_z_q;

    logic [LINKS-1:0]  wr_ctrl, wr_errclr, snap_clr;
    logic              glb_wr, softrst_wr;
    logic [31:0]       rd_mux;

    rst_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    function automatic logic [31:0] snap_word(input logic [SNAP_W-1:0] s, input logic [2:0] w);
        logic [SNAP_W-1:0] sh;
        sh = s >> {w, 5'd0};
        if ({1'b0, w} < 4'(NW))
            snap_word = sh[31:0];
        else
            snap_word = '0;
    endfunction

    always_comb begin
        wr_ctrl   = '0;
        wr_errclr = '0;
        snap_clr  = '0;
        for (int k = 0; k < LINKS; k++) begin
            if (wr_en && win == WIN_W'(k)) begin
                if (word_addr == 6'd0) wr_ctrl[k]   = 1'b1;
                if (word_addr == 6'd2) wr_errclr[k] = 1'b1;
            end
            snap_clr[k] = wr_ctrl[k] & wr_data[31];
        end
    end

    assign glb_wr     = wr_en && (win == WIN_GLB);
    assign softrst_wr = glb_wr && (word_addr == 6'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LINKS; k++) begin
                ctrl_q[k]    <= '0;
                errcnt_q[k]  <= '0;
                snap_of_q[k] <= '0;
                snap_ol_q[k] <= '0;
                snap_if_q[k] <= '0;
                snap_il_q[k] <= '0;
            end
            sticky_q <= '0;
            align_q  <= '0;
            arm_of_q <= '1;
            arm_if_q <= '1;
        end else begin
            align_q <= align_error;
            for (int k = 0; k < LINKS; k++) begin
                if (wr_ctrl[k])
                    ctrl_q[k] <= wr_data[12:0];
                // a clearing write beats a coincident rising edge
                if (wr_errclr[k]) begin
                    errcnt_q[k] <= '0;
                    sticky_q[k] <= 1'b0;
                end else if (align_error[k] && !align_q[k]) begin
                    sticky_q[k] <= 1'b1;
                    if (errcnt_q[k] != 16'hFFFF)
                        errcnt_q[k] <= errcnt_q[k] + 16'd1;
                end
                if (snap_clr[k]) begin
                    arm_of_q[k] <= 1'b1;
                end else if (data_out_first_valid[k] && arm_of_q[k]) begin
                    snap_of_q[k] <= data_out_first[k*SNAP_W +: SNAP_W];
                    arm_of_q[k]  <= 1'b0;
                end
                if (snap_clr[k]) begin
                    arm_if_q[k] <= 1'b1;
                end else if (data_in_first_valid[k] && arm_if_q[k]) begin
                    snap_if_q[k] <= data_in_first[k*SNAP_W +: SNAP_W];
                    arm_if_q[k]  <= 1'b0;
                end
                if (data_out_last_valid[k])
                    snap_ol_q[k] <= data_out_last[k*SNAP_W +: SNAP_W];
                if (data_in_last_valid[k])
                    snap_il_q[k] <= data_in_last[k*SNAP_W +: SNAP_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delay_x_q <= '0;
            delay_y_q <= '0;
            delay_z_q <= '0;
        end else if (glb_wr) begin
            if (word_addr == 6'd0) delay_x_q <= wr_data;
            if (word_addr == 6'd1) delay_y_q <= wr_data;
            if (word_addr == 6'd2) delay_z_q <= wr_data;
        end
    end

    always_comb begin
        csr_patgen_en    = '0;
        csr_patgen_sel   = '0;
        csr_patgen_cnt   = '0;
        csr_cntuspatt_en = '0;
        for (int k = 0; k < LINKS; k++) begin
            csr_patgen_en[k]          = ctrl_q[k][0];
            csr_patgen_sel[2*k +: 2]  = ctrl_q[k][2:1];
            csr_patgen_cnt[9*k +: 9]  = ctrl_q[k][11:3];
            csr_cntuspatt_en[k]       = ctrl_q[k][12];
        end
    end

    assign o_delay_x_value = delay_x_q;
    assign o_delay_y_value = delay_y_q;
    assign o_delay_z_value = delay_z_q;

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < LINKS; k++) begin
            if (win == WIN_W'(k)) begin
                case (grp)
                    3'd0: begin
                        case (wsel)
                            3'd0:    rd_mux = {19'd0, ctrl_q[k]};
                            3'd1:    rd_mux = {28'd0, sticky_q[k], align_error[k], chkr_pass[2*k +: 2]};
                            3'd2:    rd_mux = {16'd0, errcnt_q[k]};
                            default: rd_mux = '0;
                        endcase
                    end
                    3'd1:    rd_mux = snap_word(snap_of_q[k], wsel);
                    3'd2:    rd_mux = snap_word(snap_ol_q[k], wsel);
                    3'd3:    rd_mux = snap_word(snap_if_q[k], wsel);
                    3'd4:    rd_mux = snap_word(snap_il_q[k], wsel);
                    default: rd_mux = '0;
                endcase
            end
        end
        if (win == WIN_GLB) begin
            case (word_addr)
                6'd0:    rd_mux = delay_x_q;
                6'd1:    rd_mux = delay_y_q;
                6'd2:    rd_mux = delay_z_q;
                6'd4:    rd_mux = {28'd0, online};
                6'd5:    rd_mux = VERSION;
                default: rd_mux = '0;
            endcase
        end
    end

    // read mux sees pre-edge register values, so a same-cycle write is not visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_datain <= '0;
            rd_dvalid <= 1'b0;
        end else begin
            rd_dvalid <= rd_en;
            if (rd_en)
                rd_datain <= rd_mux;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HOLD;
            cnt_q   <= RELOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HOLD: begin
                if (softrst_wr) begin
                    cnt_d = RELOAD;
                end else if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RUN: begin
                if (softrst_wr) begin
                    state_d = HOLD;
                    cnt_d   = RELOAD;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = RELOAD;
            end
        endcase
    end

    assign axist_rstn_out = (state_q == RUN);

endmodule

// File: tb/tb_axi_st_csr_ctrl_multi.sv
// Bench for axi_st_csr_ctrl_multi (LINKS=2, SNAP_W=128): register vector table,
// read scoreboard, and hand sequences for counters, snapshots and reset timing.
`timescale 1ns/1ps
module tb_axi_st_csr_ctrl_multi;

    localparam int LINKS  = 2;
    localparam int SNAP_W = 128;
    localparam int NW     = SNAP_W / 32;
    localparam int NV     = 24;

    logic                    clk, rst;
    logic [15:0]             wr_rd_addr;
    logic                    wr_en, rd_en;
    logic [31:0]             wr_data;
    logic [31:0]             rd_datain;
    logic                    rd_dvalid;
    logic [2*LINKS-1:0]      chkr_pass;
    logic [LINKS-1:0]        align_error;
    logic [3:0]              online;
    logic [LINKS*SNAP_W-1:0] data_out_first, data_out_last, data_in_first, data_in_last;
    logic [LINKS-1:0]        data_out_first_valid, data_out_last_valid;
    logic [LINKS-1:0]        data_in_first_valid, data_in_last_valid;
    logic [LINKS-1:0]        csr_patgen_en, csr_cntuspatt_en;
    logic [2*LINKS-1:0]      csr_patgen_sel;
    logic [9*LINKS-1:0]      csr_patgen_cnt;
    logic [31:0]             o_delay_x_value, o_delay_y_value, o_delay_z_value;
    logic                    axist_rstn_out;

    axi_st_csr_ctrl_multi #(
        .LINKS(LINKS), .SNAP_W(SNAP_W), .ADDR_W(16), .RST_HOLD(16), .VERSION(32'h0002_0000)
    ) dut (
        .clk(clk), .rst(rst), .wr_rd_addr(wr_rd_addr), .wr_en(wr_en), .rd_en(rd_en),
        .wr_data(wr_data), .rd_datain(rd_datain), .rd_dvalid(rd_dvalid),
        .chkr_pass(chkr_pass), .align_error(align_error), .online(online),
        .data_out_first(data_out_first), .data_out_last(data_out_last),
        .data_in_first(data_in_first), .data_in_last(data_in_last),
        .data_out_first_valid(data_out_first_valid), .data_out_last_valid(data_out_last_valid),
        .data_in_first_valid(data_in_first_valid), .data_in_last_valid(data_in_last_valid),
        .csr_patgen_en(csr_patgen_en), .csr_patgen_sel(csr_patgen_sel),
        .csr_patgen_cnt(csr_patgen_cnt), .csr_cntuspatt_en(csr_cntuspatt_en),
        .o_delay_x_value(o_delay_x_value), .o_delay_y_value(o_delay_y_value),
        .o_delay_z_value(o_delay_z_value), .axist_rstn_out(axist_rstn_out)
    );

    typedef struct packed {
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } vec_t;

    typedef struct packed {
        logic [31:0] exp;
        logic [15:0] addr;
    } sb_t;

    vec_t vecs[NV];
    sb_t  sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n;

    logic [127:0] sa, sb_v, sc, sd, se;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // one clock; checks read-valid timing and retires scoreboard entries
    task automatic tick();
        logic exp_dv;
        sb_t  e;
        exp_dv = rd_en && !rst;
        @(posedge clk);
        #1;
        chk("rd_dvalid", 32'(rd_dvalid), 32'(exp_dv));
        if (rd_dvalid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: got data %h with no read outstanding", rd_datain);
            end else begin
                e = sb.pop_front();
                n_tests++;
                if (rd_datain !== e.exp) begin
                    n_fail++;
                    $display("FAIL read@%h: got %h expected %h", e.addr, rd_datain, e.exp);
                end
            end
        end
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] e);
        wr_rd_addr = a;
        rd_en      = 1'b1;
        sb.push_back('{exp: e, addr: a});
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        wr_rd_addr = a;
        wr_data    = d;
        wr_en      = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_snap(input logic [15:0] base, input logic [127:0] v);
        for (int i = 0; i < NW; i++)
            rd(base + 16'(4 * i), v[32*i +: 32]);
    endtask

    task automatic count_hold(input string nm, input int exp_cycles);
        n = 0;
        while (!axist_rstn_out && n < 200) begin
            tick();
            n++;
        end
        chk(nm, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 16'h0F00, 32'd5,         32'd0};
        vecs[1]  = '{1'b1, 1'b0, 16'h0F04, 32'h1234_5678, 32'd0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0F08, 32'hDEAD_BEEF, 32'd0};
        vecs[3]  = '{1'b1, 1'b1, 16'h0F00, 32'd9,         32'd5};
        vecs[4]  = '{1'b0, 1'b1, 16'h0F00, 32'd0,         32'd9};
        vecs[5]  = '{1'b0, 1'b1, 16'h0F04, 32'd0,         32'h1234_5678};
        vecs[6]  = '{1'b0, 1'b1, 16'h0F08, 32'd0,         32'hDEAD_BEEF};
        vecs[7]  = '{1'b0, 1'b1, 16'h0F14, 32'd0,         32'h0002_0000};
        vecs[8]  = '{1'b0, 1'b1, 16'h0E00, 32'd0,         32'd0};
        vecs[9]  = '{1'b0, 1'b1, 16'h0F0C, 32'd0,         32'd0};
        vecs[10] = '{1'b0, 1'b1, 16'h0200, 32'd0,         32'd0};
        vecs[11] = '{1'b0, 1'b1, 16'h0F10, 32'd0,         32'h0000_000A};
        vecs[12] = '{1'b1, 1'b0, 16'h0000, 32'h8000_0005, 32'd0};
        vecs[13] = '{1'b0, 1'b1, 16'h0000, 32'd0,         32'h0000_0005};
        vecs[14] = '{1'b0, 1'b1, 16'h0100, 32'd0,         32'h0000_1FFF};
        vecs[15] = '{1'b0, 1'b1, 16'h0103, 32'd0,         32'h0000_1FFF};
        vecs[16] = '{1'b0, 1'b1, 16'h0004, 32'd0,         32'h0000_0002};
        vecs[17] = '{1'b0, 1'b1, 16'h0104, 32'd0,         32'h0000_0001};
        vecs[18] = '{1'b0, 1'b1, 16'h00FC, 32'd0,         32'd0};
        vecs[19] = '{1'b1, 1'b0, 16'h0E00, 32'hFFFF_FFFF, 32'd0};
        vecs[20] = '{1'b0, 1'b1, 16'h0F00, 32'd0,         32'd9};
        vecs[21] = '{1'b0, 1'b1, 16'h000C, 32'd0,         32'd0};
        vecs[22] = '{1'b1, 1'b0, 16'h0104, 32'hFFFF_FFFF, 32'd0};
        vecs[23] = '{1'b0, 1'b1, 16'h0104, 32'd0,         32'h0000_0001};

        sa   = {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0};
        sb_v = {32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hB0B0_B0B0};
        sc   = {32'hC3C3_C3C3, 32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
        sd   = {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0};
        se   = {32'hE3E3_E3E3, 32'hE2E2_E2E2, 32'hE1E1_E1E1, 32'hE0E0_E0E0};

        rst = 1'b1;
        wr_rd_addr = '0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        chkr_pass = 4'b01_10; align_error = '0; online = 4'hA;
        data_out_first = '0; data_out_last = '0; data_in_first = '0; data_in_last = '0;
        data_out_first_valid = '0; data_out_last_valid = '0;
        data_in_first_valid = '0; data_in_last_valid = '0;

        tick();
        tick();
        chk("reset rstn_out",  32'(axist_rstn_out), 32'd0);
        chk("reset patgen_en", 32'(csr_patgen_en), 32'd0);
        chk("reset patgen_cnt", 32'(csr_patgen_cnt), 32'd0);
        chk("reset delay_x",   o_delay_x_value, 32'd0);
        chk("reset rd_datain", rd_datain, 32'd0);

        rst = 1'b0;
        count_hold("por hold cycles", 16);
        chk("rstn_out high", 32'(axist_rstn_out), 32'd1);

        wr(16'h0100, 32'h0000_1FFF);
        chk("l1 patgen_en",   32'(csr_patgen_en), 32'h2);
        chk("l1 patgen_sel",  32'(csr_patgen_sel), 32'hC);
        chk("l1 patgen_cnt",  32'(csr_patgen_cnt), 32'h3_FE00);
        chk("l1 cntuspatt",   32'(csr_cntuspatt_en), 32'h2);

        for (int v = 0; v < NV; v++) begin
            wr_rd_addr = vecs[v].addr;
            wr_data    = vecs[v].wdata;
            wr_en      = vecs[v].we;
            rd_en      = vecs[v].re;
            if (vecs[v].re)
                sb.push_back('{exp: vecs[v].rexp, addr: vecs[v].addr});
            tick();
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
        chk("both patgen_en",  32'(csr_patgen_en), 32'h3);
        chk("both patgen_sel", 32'(csr_patgen_sel), 32'hE);
        chk("both patgen_cnt", 32'(csr_patgen_cnt), 32'h3_FE00);
        chk("delay_x out",     o_delay_x_value, 32'd9);
        chk("delay_y out",     o_delay_y_value, 32'h1234_5678);
        chk("delay_z out",     o_delay_z_value, 32'hDEAD_BEEF);

        for (int p = 0; p < 3; p++) begin
            align_error[0] = 1'b1;
            tick();
            align_error[0] = 1'b0;
            tick();
        end
        rd(16'h0008, 32'd3);
        rd(16'h0004, 32'hA);
        align_error[0] = 1'b1;
        wr(16'h0008, 32'd0);
        rd(16'h0008, 32'd0);
        rd(16'h0004, 32'h6);
        tick();
        rd(16'h0008, 32'd0);
        align_error[0] = 1'b0;
        tick();
        align_error[0] = 1'b1;
        tick();
        align_error[0] = 1'b0;
        rd(16'h0008, 32'd1);
        rd(16'h0108, 32'd0);

        data_out_first[127:0] = sa;
        data_out_first_valid  = 2'b01;
        tick();
        data_out_first[127:0] = sb_v;
        tick();
        data_out_first_valid  = 2'b00;
        rd_snap(16'h0020, sa);
        rd(16'h0030, 32'd0);
        rd(16'h003C, 32'd0);
        rd(16'h0120, 32'd0);

        wr(16'h0000, 32'h8000_0005);
        data_out_first[127:0] = sc;
        tick();
        data_out_first_valid  = 2'b01;
        tick();
        data_out_first_valid  = 2'b00;
        rd_snap(16'h0020, sc);

        data_out_first[127:0] = sd;
        data_out_first_valid  = 2'b01;
        wr(16'h0000, 32'h8000_0005);
        data_out_first_valid  = 2'b00;
        rd(16'h0020, sc[31:0]);
        data_out_first[127:0] = se;
        data_out_first_valid  = 2'b01;
        tick();
        data_out_first_valid  = 2'b00;
        rd_snap(16'h0020, se);

        data_out_last[127:0] = sa;
        data_out_last_valid  = 2'b01;
        tick();
        data_out_last[127:0] = sb_v;
        tick();
        data_out_last_valid  = 2'b00;
        data_out_last[127:0] = sc;
        tick();
        rd_snap(16'h0040, sb_v);

        data_in_first[255:128] = sc;
        data_in_first_valid    = 2'b10;
        tick();
        data_in_first[255:128] = sd;
        tick();
        data_in_first_valid    = 2'b00;
        rd_snap(16'h0160, sc);
        rd(16'h0060, 32'd0);
        data_in_last[255:128] = se;
        data_in_last_valid    = 2'b10;
        tick();
        data_in_last_valid    = 2'b00;
        rd(16'h0180, se[31:0]);
        rd(16'h018C, se[127:96]);

        wr(16'h0F0C, 32'h0);
        chk("softrst low", 32'(axist_rstn_out), 32'd0);
        n = 0;
        while (!axist_rstn_out && n < 200) begin
            if (n == 9) begin
                wr_rd_addr = 16'h0F0C;
                wr_en      = 1'b1;
            end
            tick();
            wr_en = 1'b0;
            n++;
        end
        chk("softrst extended hold", 32'(n), 32'd26);
        chk("delay_x after softrst", o_delay_x_value, 32'd9);
        rd(16'h0F00, 32'd9);
        rd(16'h0100, 32'h0000_1FFF);

        rd(16'h0F04, 32'h1234_5678);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst dvalid",    32'(rd_dvalid), 32'd0);
        chk("async rst rd_datain", rd_datain, 32'd0);
        chk("async rst delay_x",   o_delay_x_value, 32'd0);
        chk("async rst patgen_en", 32'(csr_patgen_en), 32'd0);
        chk("async rst rstn_out",  32'(axist_rstn_out), 32'd0);
        wr_rd_addr = 16'h0F00;
        rd_en      = 1'b1;
        tick();
        rd_en = 1'b0;
        rst   = 1'b0;
        count_hold("post-rst hold cycles", 16);
        rd(16'h0F00, 32'd0);
        rd(16'h0008, 32'd0);
        rd(16'h0020, 32'd0);
        rd(16'h0100, 32'd0);
        tick();

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
